// File: rtl/divider_restoring_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : divider_restoring_seq_if
// Purpose  : ALU <-> restoring divider request/result bundle.
// Revision : 1.0
// ============================================================================
interface divider_restoring_seq_if #(
    parameter int WIDTH = 64
);
    logic                 flush;
    logic                 valid;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 done;
    logic [2*WIDTH-1:0]   res;

    modport master (
        output flush,
        output valid,
        output a,
        output b,
        input  done,
        input  res
    );

    modport slave (
        input  flush,
        input  valid,
        input  a,
        input  b,
        output done,
        output res
    );
endinterface
`default_nettype wire

// File: rtl/divider_restoring_seq.sv
`default_nettype none
// ============================================================================
// Module   : divider_restoring_seq
// Purpose  : Unsigned multicycle restoring divider, one quotient bit per cycle,
//            res = {remainder, quotient}. Define DIV_EARLY_OUT_EN to finish
//            a<b and b==1 in one cycle.
// Revision : 1.0
// ============================================================================
module divider_restoring_seq #(
    parameter int WIDTH = 64
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    divider_restoring_seq_if.slave    bus
);
    localparam int                   c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [WIDTH-1:0]     c_one   = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_dvd;
    logic [WIDTH-1:0]      r_dsr;
    logic [WIDTH-1:0]      r_rem;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_done;
    logic [2*WIDTH-1:0]    r_res;

    logic                  w_load;
    logic                  w_iter;
    logic                  w_quick;
    logic [2*WIDTH-1:0]    w_quick_res;
    logic [WIDTH:0]        w_t;
    logic [WIDTH:0]        w_diff;
    logic                  w_ge;
    logic [WIDTH-1:0]      w_rem_next;
    logic [WIDTH-1:0]      w_dvd_next;
    logic                  w_new_ops;

    // Operands that resolve without iterating.
    always_comb begin
        w_quick     = 1'b0;
        w_quick_res = '0;
        if (bus.b == '0) begin
            w_quick     = 1'b1;
            w_quick_res = {bus.a, {WIDTH{1'b1}}};
        end
`ifdef DIV_EARLY_OUT_EN
        else if (bus.b == c_one) begin
            w_quick     = 1'b1;
            w_quick_res = {{WIDTH{1'b0}}, bus.a};
        end else if (bus.a < bus.b) begin
            w_quick     = 1'b1;
            w_quick_res = {bus.a, {WIDTH{1'b0}}};
        end
`endif
    end

    // W+1-bit trial subtract keeps the carry out of the shifted remainder.
    always_comb begin
        w_t        = {r_rem, r_dvd[WIDTH-1]};
        w_diff     = w_t - {1'b0, r_dsr};
        w_ge       = ~w_diff[WIDTH];
        w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
        w_dvd_next = {r_dvd[WIDTH-2:0], w_ge};
    end

    assign w_new_ops = (bus.a != r_a) || (bus.b != r_dsr);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_iter       = 1'b0;
        if (bus.flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid) begin
                        w_load       = 1'b1;
                        w_state_next = w_quick ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!bus.valid) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_iter = 1'b1;
                        if (r_count == c_last) begin
                            w_state_next = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.valid) begin
                        w_state_next = S_IDLE;
                    end else if (w_new_ops) begin
                        w_load       = 1'b1;
                        w_state_next = w_quick ? S_DONE : S_BUSY;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_rem   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next == S_DONE);
            if (w_load) begin
                r_a     <= bus.a;
                r_dvd   <= bus.a;
                r_dsr   <= bus.b;
                r_rem   <= '0;
                r_count <= '0;
                if (w_quick) begin
                    r_res <= w_quick_res;
                end
            end else if (w_iter) begin
                r_rem   <= w_rem_next;
                r_dvd   <= w_dvd_next;
                r_count <= r_count + 1'b1;
                if (r_count == c_last) begin
                    r_res <= {w_rem_next, w_dvd_next};
                end
            end
        end
    end

    assign bus.done = r_done;
    assign bus.res  = r_res;
endmodule
`default_nettype wire
